commit_trace_queue: RTL and testbench
=====================================

// Module: commit_trace_queue
// PURPOSE
//  Elastic buffer between the core's retire ports and the per-cycle cosim commit/judge checker.
//  Captures up to COMMITS retired instructions per cycle (PC, instruction, optional GPR writeback).
//  Compacts them in slot order and presents them one per cycle on a valid/ready port.
//  The checker therefore sees a strict program-order stream regardless of retire width or stalls.
// PARAMETERS
//  COMMITS  2   retire slots sampled per cycle (1..4)
//  DEPTH    16  queue entries; power of 2, >= 2*COMMITS
//  XLEN     64  PC/data width
// PORTS
//  clock          in   1             sole clock, rising edge
//  reset_n        in   1             synchronous active-low reset
//  in_valid       in   COMMITS       per-slot retire valid; slot 0 is oldest
//  in_pc          in   COMMITS*XLEN  per-slot PC, slot i at [i*XLEN +: XLEN]
//  in_insn        in   COMMITS*32    per-slot instruction bits
//  in_wen         in   COMMITS       per-slot GPR writeback valid
//  in_waddr       in   COMMITS*5     per-slot destination register
//  in_wdata       in   COMMITS*XLEN  per-slot writeback data
//  in_ready       out  1             free entries >= COMMITS
//  out_valid      out  1             head entry available
//  out_ready      in   1             checker consumes head
//  out_pc         out  XLEN          head PC
//  out_insn       out  32            head instruction
//  out_wen        out  1             head writeback valid
//  out_waddr      out  5             head destination register
//  out_wdata      out  XLEN          head writeback data
//  out_seq        out  64            retire sequence number of head, starts at 0
//  count          out  $clog2(DEPTH)+1  current occupancy
//  high_water     out  $clog2(DEPTH)+1  max occupancy since reset
//  overflow       out  1             sticky: retire attempted while !in_ready
// BEHAVIOUR
//  - Reset (reset_n==0 at posedge): wr/rd pointers, count, high_water, out_seq, overflow all clear.
//    out_valid=0. Payload outputs are don't-care while out_valid=0.
//    Reset mid-stream discards all queued entries, and inputs in that cycle are ignored.
//  - Enqueue, when in_ready=1: all slots with in_valid=1 are written in ascending slot order into consecutive entries.
//    Invalid slots are skipped (e.g. in_valid=2'b10 writes slot 1 only). Number written k = popcount(in_valid).
//  - in_waddr/in_wdata are stored as-is when in_wen=0; out_wen=0 marks them meaningless.
//    Writes to x0 with in_wen=1 are passed through unchanged, and the checker decides what to do with them.
//  - in_ready is combinational from count only: in_ready = (DEPTH-count) >= COMMITS.
//    It does not depend on the same-cycle dequeue.
//  - Overflow: any in_valid bit set while in_ready=0 drops the whole cycle's slots.
//    It also sets overflow, which stays 1 until reset. Queue contents are unaffected.
//  - Dequeue: fire = out_valid & out_ready. On fire, the head advances and out_seq increments by 1.
//    out_* are driven from the head entry (registered storage, no comb path in->out).
//  - Latency: an entry written at edge N is visible on out_* after edge N; min in->out latency is 1 cycle.
//    An empty queue never bypasses.
//  - Simultaneous enqueue k and dequeue: count_next = count + k - fire, and both are legal when full-minus-COMMITS.
//  - Pointers are $clog2(DEPTH)+1 bits and wrap modulo 2*DEPTH. Full/empty comes from count, not pointer compare.
//  - high_water is updated with count_next when count_next > high_water.
//  - out_valid = (count != 0). out_* hold stable while out_valid & !out_ready (no payload change without fire).
//  - out_seq is 64-bit and wraps modulo 2^64 (never reached in practice).
// TESTING
//  1. Reset, in_valid=2'b01 pc=0x80000000 insn=0x00000013, out_ready=1.
//     -> next cycle out_valid=1, out_pc=0x80000000, out_seq=0; following cycle count=0.
//  2. in_valid=2'b11 (pc 0x1000,0x1004), out_ready=0 for 3 cycles.
//     -> count=2, out_pc stable 0x1000; then out_ready=1 gives 0x1000 seq0, 0x1004 seq1, in order.
//  3. in_valid=2'b10 pc[1]=0x2004 wen=1 waddr=5 wdata=0xdead.
//     -> single entry: out_pc=0x2004, out_wen=1, out_waddr=5, out_wdata=0xdead.
//  4. out_ready=0, dual-retire 8 cycles (DEPTH=16).
//     -> count=16, in_ready=0 from count>=15. A further retire sets overflow=1 and count stays 16.
//     -> drain yields 16 entries, seq 0..15, in order.
//  5. Steady dual-retire with out_ready toggled 1/0 across 40 cycles.
//     -> pointer wrap exercised, stream order and seq monotonic, and high_water matches the peak count.
//  6. Queue holding 6 entries, reset_n=0 one cycle with in_valid=2'b11.
//     -> count=0, out_valid=0, overflow=0, out_seq=0, high_water=0 afterwards.

Source files
------------

// File: rtl/commit_trace_queue_if.sv
// Retire-side and checker-side signals of the commit trace queue.
// The queue uses the slave modport; the core/checker side uses master.
interface commit_trace_queue_if #(
  parameter int COMMITS = 2,
  parameter int DEPTH   = 16,
  parameter int XLEN    = 64
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [COMMITS-1:0]      in_valid;
  logic [COMMITS*XLEN-1:0] in_pc;
  logic [COMMITS*32-1:0]   in_insn;
  logic [COMMITS-1:0]      in_wen;
  logic [COMMITS*5-1:0]    in_waddr;
  logic [COMMITS*XLEN-1:0] in_wdata;
  logic                    in_ready;

  logic                    out_valid;
  logic                    out_ready;
  logic [XLEN-1:0]         out_pc;
  logic [31:0]             out_insn;
  logic                    out_wen;
  logic [4:0]              out_waddr;
  logic [XLEN-1:0]         out_wdata;
  logic [63:0]             out_seq;

  logic [CW-1:0]           count;
  logic [CW-1:0]           high_water;
  logic                    overflow;

  modport master (
    output in_valid, in_pc, in_insn, in_wen, in_waddr, in_wdata, out_ready,
    input  in_ready, out_valid, out_pc, out_insn, out_wen, out_waddr, out_wdata,
           out_seq, count, high_water, overflow
  );

  modport slave (
    input  in_valid, in_pc, in_insn, in_wen, in_waddr, in_wdata, out_ready,
    output in_ready, out_valid, out_pc, out_insn, out_wen, out_waddr, out_wdata,
           out_seq, count, high_water, overflow
  );
endinterface

// File: rtl/commit_trace_queue.sv
// Elastic queue that compacts up to COMMITS retired instructions per cycle
// into a one-per-cycle, program-ordered valid/ready stream for the cosim checker.
module commit_trace_queue #(
  parameter int COMMITS = 2,
  parameter int DEPTH   = 16,
  parameter int XLEN    = 64
) (
  input logic                 clock,
  input logic                 reset_n,
  commit_trace_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [31:0]     insn_mem  [DEPTH];
  logic            wen_mem   [DEPTH];
  logic [4:0]      waddr_mem [DEPTH];
  logic [XLEN-1:0] wdata_mem [DEPTH];

  logic [CW-1:0] wr_ptr, rd_ptr, count, high_water;
  logic [63:0]   seq;
  logic          overflow;

  logic [CW-1:0] k, k_acc, count_next;
  logic [AW-1:0] slot_idx [COMMITS];
  logic          ready, accept, fire, out_valid;

  // Number of valid slots strictly below slot n; gives each slot its compacted offset.
  function automatic logic [CW-1:0] ones_below(input logic [COMMITS-1:0] v, input int n);
    logic [CW-1:0] c;
    c = '0;
    for (int j = 0; j < COMMITS; j++)
      if (j < n && v[j]) c = c + CW'(1);
    return c;
  endfunction

  always_comb begin
    k      = ones_below(bus.in_valid, COMMITS);
    ready  = (count <= CW'(DEPTH - COMMITS));
    accept = ready && (|bus.in_valid);
    k_acc  = accept ? k : '0;
    out_valid  = (count != '0);
    fire       = out_valid && bus.out_ready;
    count_next = count + k_acc - CW'(fire);
    for (int i = 0; i < COMMITS; i++)
      slot_idx[i] = AW'(wr_ptr + ones_below(bus.in_valid, i));
  end

  // Control state: pointers wrap modulo 2*DEPTH, occupancy lives in count.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      high_water <= '0;
      seq        <= '0;
      overflow   <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + k_acc;
      if (fire) begin
        rd_ptr <= rd_ptr + CW'(1);
        seq    <= seq + 64'd1;
      end
      count <= count_next;
      if (count_next > high_water) high_water <= count_next;
      if ((|bus.in_valid) && !ready) overflow <= 1'b1;
    end
  end

  // Payload storage; writes are gated during reset so the discarded cycle leaves no trace.
  always_ff @(posedge clock) begin
    if (reset_n && accept) begin
      for (int i = 0; i < COMMITS; i++) begin
        if (bus.in_valid[i]) begin
          pc_mem[slot_idx[i]]    <= bus.in_pc[i*XLEN +: XLEN];
          insn_mem[slot_idx[i]]  <= bus.in_insn[i*32 +: 32];
          wen_mem[slot_idx[i]]   <= bus.in_wen[i];
          waddr_mem[slot_idx[i]] <= bus.in_waddr[i*5 +: 5];
          wdata_mem[slot_idx[i]] <= bus.in_wdata[i*XLEN +: XLEN];
        end
      end
    end
  end

  assign bus.in_ready   = ready;
  assign bus.out_valid  = out_valid;
  assign bus.out_pc     = pc_mem[rd_ptr[AW-1:0]];
  assign bus.out_insn   = insn_mem[rd_ptr[AW-1:0]];
  assign bus.out_wen    = wen_mem[rd_ptr[AW-1:0]];
  assign bus.out_waddr  = waddr_mem[rd_ptr[AW-1:0]];
  assign bus.out_wdata  = wdata_mem[rd_ptr[AW-1:0]];
  assign bus.out_seq    = seq;
  assign bus.count      = count;
  assign bus.high_water = high_water;
  assign bus.overflow   = overflow;
endmodule

// File: tb/tb_commit_trace_queue.sv
// Directed and randomized bench for commit_trace_queue against a queue-based reference model.
module tb_commit_trace_queue;
  localparam int COMMITS = 2;
  localparam int DEPTH   = 16;
  localparam int XLEN    = 64;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  commit_trace_queue_if #(.COMMITS(COMMITS), .DEPTH(DEPTH), .XLEN(XLEN)) bus ();

  commit_trace_queue #(.COMMITS(COMMITS), .DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [63:0] pc;
    logic [31:0] insn;
    logic        wen;
    logic [4:0]  waddr;
    logic [63:0] wdata;
  } ent_t;

  ent_t        q[$];
  logic [63:0] m_seq = '0;
  int          m_hw  = 0;
  bit          m_ovf = 1'b0;
  int          peak  = 0;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_in();
    bus.in_valid = '0;
    bus.in_pc    = '0;
    bus.in_insn  = '0;
    bus.in_wen   = '0;
    bus.in_waddr = '0;
    bus.in_wdata = '0;
  endtask

  task automatic set_slot(input int i, input logic [63:0] pc, input logic [31:0] insn,
                          input logic wen, input logic [4:0] waddr, input logic [63:0] wdata);
    bus.in_pc[i*XLEN +: XLEN] = pc;
    bus.in_insn[i*32 +: 32]   = insn;
    bus.in_wen[i]             = wen;
    bus.in_waddr[i*5 +: 5]    = waddr;
    bus.in_wdata[i*XLEN +: XLEN] = wdata;
  endtask

  task automatic rand_slots();
    for (int i = 0; i < COMMITS; i++)
      set_slot(i, {$urandom, $urandom}, $urandom, 1'($urandom_range(0, 1)),
               5'($urandom_range(0, 31)), {$urandom, $urandom});
  endtask

  task automatic check_outputs();
    chk("count",      64'(bus.count),      64'(q.size()));
    chk("out_valid",  64'(bus.out_valid),  64'(q.size() != 0));
    chk("in_ready",   64'(bus.in_ready),   64'((DEPTH - q.size()) >= COMMITS));
    chk("high_water", 64'(bus.high_water), 64'(m_hw));
    chk("overflow",   64'(bus.overflow),   64'(m_ovf));
    chk("out_seq",    bus.out_seq,         m_seq);
    if (q.size() != 0) begin
      chk("out_pc",    bus.out_pc,           q[0].pc);
      chk("out_insn",  64'(bus.out_insn),    64'(q[0].insn));
      chk("out_wen",   64'(bus.out_wen),     64'(q[0].wen));
      chk("out_waddr", 64'(bus.out_waddr),   64'(q[0].waddr));
      chk("out_wdata", bus.out_wdata,        q[0].wdata);
    end
  endtask

  // One clock: model follows the stated queue rules on the inputs seen at the edge.
  task automatic tick();
    ent_t e;
    bit   rdy;
    bit   fire;
    @(posedge clock);
    if (!reset_n) begin
      q.delete();
      m_seq = '0;
      m_hw  = 0;
      m_ovf = 1'b0;
      peak  = 0;
    end else begin
      rdy  = (DEPTH - q.size()) >= COMMITS;
      fire = (q.size() != 0) && bus.out_ready;
      if (fire) begin
        void'(q.pop_front());
        m_seq = m_seq + 64'd1;
      end
      if (bus.in_valid != '0) begin
        if (rdy) begin
          for (int i = 0; i < COMMITS; i++) begin
            if (bus.in_valid[i]) begin
              e.pc    = bus.in_pc[i*XLEN +: XLEN];
              e.insn  = bus.in_insn[i*32 +: 32];
              e.wen   = bus.in_wen[i];
              e.waddr = bus.in_waddr[i*5 +: 5];
              e.wdata = bus.in_wdata[i*XLEN +: XLEN];
              q.push_back(e);
            end
          end
        end else begin
          m_ovf = 1'b1;
        end
      end
      if (q.size() > m_hw) m_hw = q.size();
      if (q.size() > peak) peak = q.size();
    end
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    clear_in();
    bus.out_ready = 1'b0;
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;

    // Single retire, immediate consume
    set_slot(0, 64'h8000_0000, 32'h0000_0013, 1'b0, 5'd0, 64'd0);
    bus.in_valid  = 2'b01;
    bus.out_ready = 1'b1;
    tick();
    chk("t1_valid", 64'(bus.out_valid), 64'd1);
    chk("t1_pc", bus.out_pc, 64'h8000_0000);
    chk("t1_seq", bus.out_seq, 64'd0);
    clear_in();
    tick();
    chk("t1_count", 64'(bus.count), 64'd0);

    // Dual retire held by backpressure
    bus.out_ready = 1'b0;
    set_slot(0, 64'h1000, 32'h1, 1'b0, 5'd0, 64'd0);
    set_slot(1, 64'h1004, 32'h2, 1'b0, 5'd0, 64'd0);
    bus.in_valid = 2'b11;
    tick();
    clear_in();
    tick();
    tick();
    chk("t2_count", 64'(bus.count), 64'd2);
    chk("t2_hold_pc", bus.out_pc, 64'h1000);
    bus.out_ready = 1'b1;
    tick();
    chk("t2_second_pc", bus.out_pc, 64'h1004);
    tick();

    // Only slot 1 valid, with writeback
    bus.out_ready = 1'b0;
    set_slot(1, 64'h2004, 32'h0050_0293, 1'b1, 5'd5, 64'hdead);
    bus.in_valid = 2'b10;
    tick();
    clear_in();
    chk("t3_count", 64'(bus.count), 64'd1);
    chk("t3_pc", bus.out_pc, 64'h2004);
    chk("t3_wen", 64'(bus.out_wen), 64'd1);
    chk("t3_waddr", 64'(bus.out_waddr), 64'd5);
    chk("t3_wdata", bus.out_wdata, 64'hdead);
    bus.out_ready = 1'b1;
    tick();

    // Fill to full, then overflow, then drain in order
    do_reset();
    bus.out_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      rand_slots();
      bus.in_valid = 2'b11;
      tick();
    end
    chk("t4_full_count", 64'(bus.count), 64'd16);
    chk("t4_not_ready", 64'(bus.in_ready), 64'd0);
    rand_slots();
    bus.in_valid = 2'b01;
    tick();
    chk("t4_overflow", 64'(bus.overflow), 64'd1);
    chk("t4_count_stays", 64'(bus.count), 64'd16);
    clear_in();
    bus.out_ready = 1'b1;
    for (int c = 0; c < 16; c++) tick();
    chk("t4_drained_seq", bus.out_seq, 64'd16);
    chk("t4_empty", 64'(bus.out_valid), 64'd0);

    // Randomized retire with toggling consumer, exercising pointer wrap
    do_reset();
    for (int c = 0; c < 40; c++) begin
      rand_slots();
      bus.in_valid  = 2'($urandom_range(0, 3));
      bus.out_ready = (c % 2 == 0);
      tick();
    end
    clear_in();
    chk("t5_high_water", 64'(bus.high_water), 64'(peak));
    bus.out_ready = 1'b1;
    for (int c = 0; c < 20; c++) tick();

    // Mid-stream reset with retires present in the reset cycle
    do_reset();
    bus.out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      rand_slots();
      bus.in_valid = 2'b11;
      tick();
    end
    chk("t6_before", 64'(bus.count), 64'd6);
    rand_slots();
    bus.in_valid = 2'b11;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    clear_in();
    chk("t6_count", 64'(bus.count), 64'd0);
    chk("t6_valid", 64'(bus.out_valid), 64'd0);
    chk("t6_overflow", 64'(bus.overflow), 64'd0);
    chk("t6_seq", bus.out_seq, 64'd0);
    chk("t6_high_water", 64'(bus.high_water), 64'd0);
    tick();
    chk("t6_still_empty", 64'(bus.count), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
